// File: rtl/clint_axi_timer.sv
// Core-local interruptor on an AXI4 slave port: prescaled 64-bit mtime,
// per-hart mtimecmp/msip registers, registered timer and software interrupts.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are high; a source holds valid and its payload
// stable until that edge, and never waits for ready before raising valid.
module clint_axi_timer #(
  parameter int          NUM_HARTS  = 1,
  parameter int          ID_W       = 4,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int          TICK_DIV   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  // AR channel
  input  logic [31:0]          araddr,
  input  logic                 arvalid,
  input  logic [ID_W-1:0]      arid,
  input  logic [7:0]           arlen,
  input  logic [2:0]           arsize,
  input  logic [1:0]           arburst,
  output logic                 arready,
  // R channel
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  output logic                 rlast,
  output logic [ID_W-1:0]      rid,
  input  logic                 rready,
  // AW channel
  input  logic [31:0]          awaddr,
  input  logic                 awvalid,
  input  logic [ID_W-1:0]      awid,
  input  logic [7:0]           awlen,
  input  logic [2:0]           awsize,
  input  logic [1:0]           awburst,
  output logic                 awready,
  // W channel
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  input  logic                 wlast,
  output logic                 wready,
  // B channel
  output logic [1:0]           bresp,
  output logic                 bvalid,
  output logic [ID_W-1:0]      bid,
  input  logic                 bready,
  // interrupts
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip_o,
  // FSM state visibility
  output logic                 dbg_r_state,
  output logic [1:0]           dbg_w_state
);

  localparam int            PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX      = PW'(TICK_DIV - 1);
  localparam logic [31:0]   CMP_OFF      = 32'h0000_4000;
  localparam logic [31:0]   MTIME_LO_OFF = 32'h0000_BFF8;
  localparam logic [31:0]   MTIME_HI_OFF = 32'h0000_BFFC;
  localparam logic [1:0]    RESP_OKAY    = 2'b00;
  localparam logic [1:0]    RESP_SLVERR  = 2'b10;

  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;
  typedef enum logic [1:0] {W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  logic [63:0]          mtime;
  logic [63:0]          mtime_next;
  logic [PW-1:0]        pre;
  logic                 tick;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;

  r_state_t    r_state;
  logic [29:0] r_addr;
  logic [7:0]  r_left;
  logic [29:0] rd_word;
  logic [31:0] rd_off;
  logic [31:0] rd_val;
  logic        rd_hit;

  w_state_t    w_state;
  logic [29:0] w_addr;
  logic [7:0]  w_len;
  logic        w_first;
  logic [31:0] w_off;
  logic        w_hit;
  logic        wr_en;

  assign tick = (pre == PRE_MAX);

  // Word whose contents the next presented read beat carries.
  always_comb begin
    rd_word = (r_state == R_IDLE) ? araddr[31:2] : (r_addr + 30'd1);
  end

  assign rd_off = {rd_word, 2'b00} - CLINT_BASE;

  // Read decode: register contents before any write landing on the same edge.
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (rd_off == 32'(4 * h)) begin
        rd_val = {31'd0, msip[h]};
        rd_hit = 1'b1;
      end
      if (rd_off == CMP_OFF + 32'(8 * h)) begin
        rd_val = mtimecmp[h][31:0];
        rd_hit = 1'b1;
      end
      if (rd_off == CMP_OFF + 32'(8 * h) + 32'd4) begin
        rd_val = mtimecmp[h][63:32];
        rd_hit = 1'b1;
      end
    end
    if (rd_off == MTIME_LO_OFF) begin
      rd_val = mtime[31:0];
      rd_hit = 1'b1;
    end
    if (rd_off == MTIME_HI_OFF) begin
      rd_val = mtime[63:32];
      rd_hit = 1'b1;
    end
  end

  assign w_off = {w_addr, 2'b00} - CLINT_BASE;
  assign wr_en = wready && wvalid && w_first;

  // Write decode: is the latched write address a mapped register.
  always_comb begin
    w_hit = (w_off == MTIME_LO_OFF) || (w_off == MTIME_HI_OFF);
    for (int h = 0; h < NUM_HARTS; h++) begin
      if ((w_off == 32'(4 * h)) || (w_off == CMP_OFF + 32'(8 * h)) ||
          (w_off == CMP_OFF + 32'(8 * h) + 32'd4)) begin
        w_hit = 1'b1;
      end
    end
  end

  // Next mtime: written bytes override, all other bytes keep the tick.
  always_comb begin
    mtime_next = mtime + {63'd0, tick};
    for (int b = 0; b < 4; b++) begin
      if (wr_en && (w_off == MTIME_LO_OFF) && wstrb[b]) begin
        mtime_next[8*b +: 8] = wdata[8*b +: 8];
      end
      if (wr_en && (w_off == MTIME_HI_OFF) && wstrb[b]) begin
        mtime_next[32 + 8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Prescaler and mtime counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre   <= '0;
      mtime <= '0;
    end else begin
      pre   <= tick ? '0 : pre + 1'b1;
      mtime <= mtime_next;
    end
  end

  // msip and mtimecmp registers, byte-enabled on the first write beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else if (wr_en) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if ((w_off == 32'(4 * h)) && wstrb[0]) msip[h] <= wdata[0];
        for (int b = 0; b < 4; b++) begin
          if ((w_off == CMP_OFF + 32'(8 * h)) && wstrb[b])
            mtimecmp[h][8*b +: 8] <= wdata[8*b +: 8];
          if ((w_off == CMP_OFF + 32'(8 * h) + 32'd4) && wstrb[b])
            mtimecmp[h][32 + 8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Timer interrupts, one cycle behind the comparison.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtip <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
    end
  end

  // Read FSM: every burst is walked as INCR, one beat per accepted rready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rid     <= '0;
      r_addr  <= '0;
      r_left  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_addr  <= araddr[31:2];
            rid     <= arid;
            r_left  <= arlen;
            rlast   <= (arlen == 8'd0);
            rdata   <= rd_val;
            rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_BURST;
          end
        end
        R_BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_addr + 30'd1;
              r_left <= r_left - 8'd1;
              rlast  <= (r_left == 8'd1);
              rdata  <= rd_val;
              rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: only the first data beat reaches the registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state <= W_ADDR;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_first <= 1'b0;
    end else begin
      case (w_state)
        W_ADDR: begin
          if (awvalid) begin
            w_addr  <= awaddr[31:2];
            bid     <= awid;
            w_len   <= awlen;
            w_first <= 1'b1;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_first <= 1'b0;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= ((w_len != 8'd0) || !w_hit) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_ADDR;
          end
        end
        default: w_state <= W_ADDR;
      endcase
    end
  end

  assign msip_o      = msip;
  assign dbg_r_state = r_state;
  assign dbg_w_state = w_state;

  // Burst type/size, sub-word address bits and the beat counter's use are
  // implied by the word-only map; fold them away explicitly.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, arburst, awsize, awburst, araddr[1:0], awaddr[1:0]};

endmodule

// File: tb/tb_clint_axi_timer.sv
// Bench for clint_axi_timer: a register-map reference model stepped each
// clock, bus driver tasks, and a second instance with a divided tick that
// shares the read channel.
module tb_clint_axi_timer;

  localparam int          NH   = 2;
  localparam int          IDW  = 4;
  localparam int          TDIV = 1;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clock, reset;
  logic [31:0] araddr;  logic arvalid;  logic [IDW-1:0] arid;  logic [7:0] arlen;
  logic [2:0] arsize;   logic [1:0] arburst;  logic arready;
  logic [31:0] rdata;   logic [1:0] rresp;  logic rvalid, rlast;  logic [IDW-1:0] rid;
  logic rready;
  logic [31:0] awaddr;  logic awvalid;  logic [IDW-1:0] awid;  logic [7:0] awlen;
  logic [2:0] awsize;   logic [1:0] awburst;  logic awready;
  logic [31:0] wdata;   logic [3:0] wstrb;  logic wvalid, wlast, wready;
  logic [1:0] bresp;    logic bvalid;  logic [IDW-1:0] bid;  logic bready;
  logic [NH-1:0] mtip, msip_o;
  logic dbg_r_state;    logic [1:0] dbg_w_state;

  logic d4_arready, d4_rvalid, d4_rlast, d4_awready, d4_wready, d4_bvalid;
  logic [31:0] d4_rdata;  logic [1:0] d4_rresp, d4_bresp;
  logic [IDW-1:0] d4_rid, d4_bid;
  logic [0:0] d4_mtip, d4_msip;
  logic d4_dbg_r;  logic [1:0] d4_dbg_w;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 0;

  clint_axi_timer #(.NUM_HARTS(NH), .ID_W(IDW), .CLINT_BASE(BASE), .TICK_DIV(TDIV)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rid(rid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready),
    .mtip(mtip), .msip_o(msip_o), .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  clint_axi_timer #(.NUM_HARTS(1), .ID_W(IDW), .CLINT_BASE(BASE), .TICK_DIV(4)) dut_div4 (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(d4_arready),
    .rdata(d4_rdata), .rresp(d4_rresp), .rvalid(d4_rvalid), .rlast(d4_rlast), .rid(d4_rid),
    .rready(rready),
    .awaddr(32'd0), .awvalid(1'b0), .awid(4'd0), .awlen(8'd0), .awsize(3'd2),
    .awburst(2'b01), .awready(d4_awready),
    .wdata(32'd0), .wstrb(4'd0), .wvalid(1'b0), .wlast(1'b0), .wready(d4_wready),
    .bresp(d4_bresp), .bvalid(d4_bvalid), .bid(d4_bid), .bready(1'b1),
    .mtip(d4_mtip), .msip_o(d4_msip), .dbg_r_state(d4_dbg_r), .dbg_w_state(d4_dbg_w)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0]   m_mtime;
  int            m_pre;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_mtip;
  logic [63:0]   d4_mtime;
  int            d4_pre;
  int            mw_req = 0;
  int            mw_done = 0;
  logic [31:0]   mw_addr, mw_data;
  logic [3:0]    mw_strb;

  function automatic logic [31:0] merge32(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_mapped(logic [31:0] addr);
    logic [31:0] off = addr - BASE;
    if (off == 32'hBFF8 || off == 32'hBFFC) return 1;
    for (int h = 0; h < NH; h++)
      if (off == 32'(4*h) || off == 32'h4000 + 32'(8*h) || off == 32'h4004 + 32'(8*h)) return 1;
    return 0;
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] off = addr - BASE;
    d = 0; r = 2'b10;
    for (int h = 0; h < NH; h++) begin
      if (off == 32'(4*h))              begin d = {31'd0, m_msip[h]}; r = 0; end
      if (off == 32'h4000 + 32'(8*h))   begin d = m_cmp[h][31:0];     r = 0; end
      if (off == 32'h4004 + 32'(8*h))   begin d = m_cmp[h][63:32];    r = 0; end
    end
    if (off == 32'hBFF8) begin d = m_mtime[31:0];  r = 0; end
    if (off == 32'hBFFC) begin d = m_mtime[63:32]; r = 0; end
  endfunction

  // The divided instance is never written, so its map is reset values plus time.
  function automatic void d4_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] off = addr - BASE;
    d = 0; r = 2'b10;
    if (off == 32'h0)                     begin d = 0;               r = 0; end
    if (off == 32'h4000 || off == 32'h4004) begin d = 32'hFFFF_FFFF; r = 0; end
    if (off == 32'hBFF8)                  begin d = d4_mtime[31:0];  r = 0; end
    if (off == 32'hBFFC)                  begin d = d4_mtime[63:32]; r = 0; end
  endfunction

  // Model state advances once per clock; interrupts see the pre-edge values.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mtime  = 0;  m_pre = 0;  m_msip = 0;  m_mtip = 0;
      m_cmp    = '{default: 64'hFFFF_FFFF_FFFF_FFFF};
      d4_mtime = 0;  d4_pre = 0;
      mw_done  = mw_req;
    end else begin
      logic [63:0] nxt;
      logic [31:0] off;
      for (int h = 0; h < NH; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
      nxt   = m_mtime + ((m_pre == TDIV - 1) ? 64'd1 : 64'd0);
      m_pre = (m_pre == TDIV - 1) ? 0 : m_pre + 1;
      if (mw_req != mw_done) begin
        off = mw_addr - BASE;
        for (int h = 0; h < NH; h++) begin
          if (off == 32'(4*h) && mw_strb[0]) m_msip[h] = mw_data[0];
          if (off == 32'h4000 + 32'(8*h)) m_cmp[h][31:0]  = merge32(m_cmp[h][31:0], mw_data, mw_strb);
          if (off == 32'h4004 + 32'(8*h)) m_cmp[h][63:32] = merge32(m_cmp[h][63:32], mw_data, mw_strb);
        end
        if (off == 32'hBFF8) nxt[31:0]  = merge32(nxt[31:0], mw_data, mw_strb);
        if (off == 32'hBFFC) nxt[63:32] = merge32(nxt[63:32], mw_data, mw_strb);
        mw_done = mw_req;
      end
      m_mtime = nxt;
      if (d4_pre == 3) begin d4_pre = 0; d4_mtime = d4_mtime + 1; end
      else d4_pre = d4_pre + 1;
    end
  end

  // Interrupt outputs are compared every cycle once out of the first reset.
  always @(negedge clock) begin
    if (mon_on) begin
      check("mtip", mtip, m_mtip);
      check("msip_o", msip_o, m_msip);
      check("d4_mtip", d4_mtip, 0);
    end
  end

  // ---------------- driver tasks (entered just after a falling edge) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int len, input logic [IDW-1:0] id);
    int n;
    logic [1:0] exp_b;
    exp_b   = (is_mapped(addr) && len == 0) ? 2'b00 : 2'b10;
    awaddr  = addr;  awid = id;  awlen = 8'(len);  awburst = 2'b01;  awvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clock); n++; end
    check("aw_timeout", 64'(n >= 50), 0);
    @(negedge clock);
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      wdata  = (i == 0) ? data : $urandom;
      wstrb  = (i == 0) ? strb : 4'hF;
      wlast  = (i == len);
      wvalid = 1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clock); n++; end
      check("w_timeout", 64'(n >= 50), 0);
      if (i == 0) begin
        mw_addr = addr;  mw_data = data;  mw_strb = strb;  mw_req++;
      end
      @(negedge clock);
    end
    wvalid = 0;  wlast = 0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    bready = 1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clock); n++; end
    check("b_timeout", 64'(n >= 50), 0);
    check("bresp", bresp, exp_b);
    check("bid", bid, id);
    @(negedge clock);
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [IDW-1:0] id,
                          input int stall_beat, input int stall_cyc);
    int n;
    logic [31:0] ed, e4;
    logic [1:0]  er, e4r;
    araddr = addr;  arid = id;  arlen = 8'(len);  arsize = 3'd2;
    arburst = 2'($urandom_range(0, 3));
    arvalid = 1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clock); n++; end
    check("ar_timeout", 64'(n >= 50), 0);
    m_read(addr, ed, er);
    d4_read(addr, e4, e4r);
    @(negedge clock);
    arvalid = 0;
    check("r_latency", rvalid, 1);
    for (int k = 0; k <= len; k++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
      check("r_timeout", 64'(n >= 50), 0);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      check("rid", rid, id);
      check("rlast", rlast, 64'(k == len));
      check("d4_rvalid", d4_rvalid, 1);
      check("d4_rdata", d4_rdata, e4);
      check("d4_rresp", d4_rresp, e4r);
      if (k == stall_beat) begin
        rready = 0;
        repeat (stall_cyc) begin
          @(negedge clock);
          check("stall_rvalid", rvalid, 1);
          check("stall_rdata", rdata, ed);
          check("stall_rlast", rlast, 64'(k == len));
        end
      end
      rready = 1;
      if (k < len) begin
        m_read(addr + 32'(4*(k+1)), ed, er);
        d4_read(addr + 32'(4*(k+1)), e4, e4r);
      end
      @(negedge clock);
      rready = 0;
    end
    check("r_done", rvalid, 0);
    check("arready_back", arready, 1);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] offs [12] = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008,
                               32'h400C, 32'h4010, 32'hBFF8, 32'hBFFC, 32'h1000, 32'hC000};
    return BASE + offs[$urandom_range(0, 11)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 0;
    araddr = 0; arvalid = 0; arid = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; rready = 0;
    awaddr = 0; awvalid = 0; awid = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    wdata = 0; wstrb = 0; wvalid = 0; wlast = 0; bready = 0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);
    check("rst_mtip", mtip, 0);
    check("rst_msip", msip_o, 0);
    check("rst_dbg_r", dbg_r_state, 0);
    check("rst_dbg_w", dbg_w_state, 0);
    check("rst_d4_ready", {d4_arready, d4_awready, d4_wready, d4_bvalid}, 4'b1100);
    check("rst_d4_out", {d4_rdata, d4_rresp, d4_rid, d4_bresp, d4_bid, d4_msip, d4_dbg_r, d4_dbg_w}, 0);
    reset = 1;
    mon_on = 1;

    // 1: mtime low read shortly after release
    repeat (9) @(negedge clock);
    axi_read(BASE + 32'hBFF8, 0, 4'h5, -1, 0);

    // 2: compare match raises mtip, moving the compare away drops it
    axi_write(BASE + 32'h4000, 32'd40, 4'hF, 0, 4'h1);
    axi_write(BASE + 32'h4004, 32'd0,  4'hF, 0, 4'h2);
    n = 0;
    while (!mtip[0] && n < 200) begin @(negedge clock); n++; end
    check("mtip0_rise", mtip[0], 1);
    axi_write(BASE + 32'h4004, 32'd1, 4'hF, 0, 4'h3);
    n = 0;
    while (mtip[0] && n < 20) begin @(negedge clock); n++; end
    check("mtip0_fall", mtip[0], 0);

    // 3: msip keeps bit 0 only
    axi_write(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF, 0, 4'h4);
    check("msip0_set", msip_o[0], 1);
    axi_read(BASE + 32'h0, 0, 4'h6, -1, 0);
    axi_write(BASE + 32'h0, 32'h0, 4'hF, 0, 4'h4);
    check("msip0_clr", msip_o[0], 0);

    // 4: bursts across the compare block, stalled on beat 1
    axi_write(BASE + 32'h4008, 32'h1234_5678, 4'hF, 0, 4'h7);
    axi_read(BASE + 32'h4000, 3, 4'hA, 1, 2);
    axi_read(BASE + 32'h4008, 3, 4'hB, 0, 3);
    axi_write(BASE + 32'h400C, 32'hCAFE_0000, 4'hC, 1, 4'h8);

    // 5: low half near wrap carries into high; unmapped writes rejected
    axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 4'h9);
    repeat (2) @(negedge clock);
    axi_read(BASE + 32'hBFFC, 0, 4'hC, -1, 0);
    axi_read(BASE + 32'hBFF8, 0, 4'hD, -1, 0);
    axi_write(BASE + 32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 4'hE);
    axi_write(BASE + 32'hBFFC, 32'h0000_00AB, 4'h1, 0, 4'hF);
    axi_read(BASE + 32'hBFF8, 1, 4'h2, 0, 1);
    axi_read(32'h0000_0000, 0, 4'h1, -1, 0);

    // randomized traffic over the map
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0) ? 1 : 0, 4'($urandom_range(0, 15)));
      else
        axi_read(pick_addr(), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // 6: reset in the middle of a burst
    araddr = BASE + 32'hBFF8;  arid = 4'h9;  arlen = 8'd3;  arburst = 2'b01;  arvalid = 1;
    check("t6_arready", arready, 1);
    @(negedge clock);
    arvalid = 0;
    check("t6_beat0", rvalid, 1);
    rready = 1;
    @(negedge clock);
    rready = 0;
    check("t6_beat1_valid", rvalid, 1);
    check("t6_beat1_last", rlast, 0);
    #2 reset = 0;
    #1;
    check("t6_rvalid_async", rvalid, 0);
    check("t6_d4_rvalid_async", d4_rvalid, 0);
    check("t6_arready_async", arready, 1);
    check("t6_dbg_r_async", dbg_r_state, 0);
    check("t6_mtip_async", mtip, 0);
    @(negedge clock);
    reset = 1;
    repeat (13) @(negedge clock);
    axi_read(BASE + 32'hBFF8, 0, 4'h3, -1, 0);
    repeat (6) @(negedge clock);
    axi_read(BASE + 32'hBFF8, 1, 4'h4, 0, 2);
    axi_read(BASE + 32'h4000, 1, 4'h5, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/clint_axi_timer.md
Name: clint_axi_timer

Overview:
- Parametrised AXI4-slave core-local interruptor; successor to the single-register free-running cycle counter.
- Provides a prescaled 64-bit mtime, per-hart mtimecmp and msip registers, registered timer/software interrupt outputs, and full AXI4 read/write handshakes.
- Reads support INCR bursts.
- Sits on the CPU's peripheral crossbar at CLINT_BASE.

Parameters:
- NUM_HARTS, 1, number of harts; sets msip/mtimecmp/interrupt vector width (1..16)
- ID_W, 4, AXI ID width
- CLINT_BASE, 32'h0200_0000, base address; offsets below are relative to it
- TICK_DIV, 1, clock cycles per mtime increment (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- araddr, arvalid, arid[ID_W], arlen[8], arsize[3], arburst[2]  in  AR channel
- arready  out  1
- rdata[32], rresp[2], rvalid, rlast, rid[ID_W]  out  R channel
- rready  in  1
- awaddr, awvalid, awid[ID_W], awlen[8], awsize[3], awburst[2]  in  AW channel
- awready  out  1
- wdata[32], wstrb[4], wvalid, wlast  in  W channel
- wready  out  1
- bresp[2], bvalid, bid[ID_W]  out  B channel
- bready  in  1
- mtip  out  NUM_HARTS  timer interrupt pending per hart
- msip_o  out  NUM_HARTS  software interrupt pending per hart

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - mtime=0, prescaler=0, msip=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - arready=1, awready=1; wready, rvalid, rlast, bvalid, mtip, msip_o = 0; rdata/rresp/rid/bresp/bid = 0.
- Register map (word offsets):
  - msip[h] at 0x0000+4h: bit0 only, upper bits read 0.
  - mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h.
  - mtime low at 0xBFF8, high at 0xBFFC.
  - Any other address reads 0 with rresp=SLVERR (2'b10); writes to it are dropped with bresp=SLVERR.
- Prescaler: counts 0..TICK_DIV-1; mtime += 1 in the cycle the prescaler wraps. mtime wraps from all-ones to 0.
- mtip[h] registered: asserts the cycle after mtime >= mtimecmp[h] (unsigned 64-bit). msip_o = msip register.
- Read FSM, states R_IDLE and R_BURST:
  - R_IDLE: arready=1. On arvalid&&arready, latch addr[31:2], arid, beat count=arlen; go to R_BURST. rvalid rises next cycle, so read latency is 1 cycle.
  - R_BURST: arready=0. rdata/rresp sampled from the current address when the beat is presented.
  - Hold rvalid, rdata, rresp, rid, rlast stable until rready.
  - On rvalid&&rready: if last, return to R_IDLE; else address += 4 and the next beat is valid on the following cycle.
  - rlast is high only on beat arlen. arburst other than INCR is treated as INCR.
- Write FSM, states W_ADDR, W_DATA, W_RESP:
  - W_ADDR: awready=1. On handshake, latch awaddr, awid, awlen; go to W_DATA.
  - W_DATA: wready=1. The first beat is applied with wstrb byte enables; later beats are accepted and discarded. On wvalid&&wready&&wlast, go to W_RESP.
  - bresp: OKAY if awlen==0 and the address is mapped. SLVERR if awlen!=0 (first beat still applied) or the address is unmapped.
  - W_RESP: bvalid=1, held until bready, then return to W_ADDR.
- Read and write FSMs run independently and concurrently.
- Collisions:
  - A write to mtime in the same cycle as a tick: the write wins for the written bytes; other bytes take the incremented value. The tick is not lost for unwritten halves.
  - A read in the same cycle as a write returns the pre-write value.
- 64-bit reads are not atomic. Software reads high/low/high.
- Reset asserted mid-transaction aborts both FSMs to their idle states immediately; no response is issued.

Test Plan:
1. Release reset, TICK_DIV=1, single read at 0xBFF8 issued 10 cycles after release -> rvalid 1 cycle after AR handshake, rdata=10 (±1 per spec latency), rresp=0, rlast=1, rid echoes arid.
2. Write mtimecmp[0]=40 (low 40, high 0), poll -> mtip[0] rises exactly 1 cycle after mtime reaches 40. Then write high=1 -> mtip[0] falls the next cycle.
3. Write msip[0]=32'hFFFF_FFFF, read back -> msip_o[0]=1, rdata=32'h1. Write 0 -> msip_o[0]=0.
4. Burst read at 0x4000, arlen=3, rready low for 2 cycles on beat 1 -> 4 beats carrying cmp0 low, cmp0 high, then next hart's words or SLVERR zeros. rdata stable while stalled; rlast only on beat 4.
5. Write 0xFFFF_FFFF to mtime low, then read mtime high after 2 ticks -> high=1, low has wrapped to small value. Write to unmapped 0x1000 -> bresp=2'b10.
6. TICK_DIV=4; assert reset mid-burst (beat 2 of 4 pending) -> rvalid=0 asynchronously, mtime=0, next AR accepted normally.
